nanosoc_rr_arbiter_sram: RTL and testbench

Round-robin output-stage arbiter for a shared nanosoc bus-matrix slave port, e.g. the SRAM banks. It chooses which of four matrix input ports drives the slave's address phase. The choice respects locked transfers, fixed-length bursts and a bounded hold on undefined-length INCR bursts. It sits between the input-stage request lines and the output-stage address/control multiplexer. It is a drop-in alternative to the fixed-priority output arbiters.

---
 rtl/nanosoc_rr_arbiter_sram_if.sv | 35 +++
 rtl/nanosoc_rr_arbiter_sram.sv | 155 +++++++++++++++
 tb/tb_nanosoc_rr_arbiter_sram.sv | 126 ++++++++++++
 3 files changed

// File: rtl/nanosoc_rr_arbiter_sram_if.sv
// Address-phase arbitration bundle between the output stage of a bus-matrix
// slave port and its round-robin arbiter.
//
// Handshake: there is no valid/ready pair. HREADYM=1 on a rising HCLK edge
// qualifies every other input as one completed transfer; with HREADYM=0 the
// arbiter ignores all inputs and holds its outputs. Outputs are registered and
// change only on edges where HREADYM=1 (arb_event also drops to 0 on stalls).
interface nanosoc_rr_arbiter_sram_if;
  logic       req_port0;
  logic       req_port1;
  logic       req_port2;
  logic       req_port3;
  logic       HREADYM;
  logic       HSELM;
  logic [1:0] HTRANSM;
  logic [2:0] HBURSTM;
  logic       HMASTLOCKM;
  logic [1:0] addr_in_port;
  logic       no_port;
  logic       arb_event;

  // Matrix side: drives requests and the current output transfer.
  modport master (
    output req_port0, req_port1, req_port2, req_port3,
    output HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    input  addr_in_port, no_port, arb_event
  );

  // Arbiter side.
  modport slave (
    input  req_port0, req_port1, req_port2, req_port3,
    input  HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    output addr_in_port, no_port, arb_event
  );
endinterface

// File: rtl/nanosoc_rr_arbiter_sram.sv
// Round-robin output-stage arbiter for a shared bus-matrix slave port.
// Picks which of four input ports owns the slave address phase, holding the
// grant across locked transfers, fixed-length bursts (with an early-termination
// guard) and a bounded number of undefined-length INCR beats.
module nanosoc_rr_arbiter_sram #(
  parameter int unsigned MAX_INCR_BEATS = 16
) (
  input logic                    HCLK,
  input logic                    HRESETn,
  nanosoc_rr_arbiter_sram_if.slave bus
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [2:0] BURST_INCR   = 3'd1;
  localparam logic [2:0] BURST_WRAP4  = 3'd2;
  localparam logic [2:0] BURST_INCR4  = 3'd3;
  localparam logic [2:0] BURST_WRAP8  = 3'd4;
  localparam logic [2:0] BURST_INCR8  = 3'd5;
  localparam logic [2:0] BURST_WRAP16 = 3'd6;
  localparam logic [2:0] BURST_INCR16 = 3'd7;

  localparam logic [4:0] MAX_BEATS = 5'(MAX_INCR_BEATS);

  logic [3:0] fcnt_q, fcnt_d;
  logic       fhold_q, fhold_d;
  logic [1:0] guard_q, guard_d;
  logic [4:0] icnt_q, icnt_d;
  logic       incr_hold_d;
  logic [1:0] addr_q, addr_d;
  logic       no_port_q, no_port_d;
  logic       arb_event_q, arb_event_d;

  logic       hold;
  logic       is_nonseq;
  logic [3:0] cand;
  logic       found;
  logic [1:0] idx;

  assign is_nonseq = (bus.HTRANSM == TRANS_NONSEQ);

  // Burst trackers: fixed-length countdown, early-termination guard, INCR beat count.
  always_comb begin
    fcnt_d  = fcnt_q;
    fhold_d = fhold_q;
    icnt_d  = icnt_q;
    if (!bus.HSELM) begin
      fcnt_d  = 4'd0;
      fhold_d = 1'b0;
      icnt_d  = 5'd0;
    end else begin
      case (bus.HTRANSM)
        TRANS_IDLE: begin
          fcnt_d  = 4'd0;
          fhold_d = 1'b0;
          icnt_d  = 5'd0;
        end
        TRANS_BUSY: begin
          fcnt_d  = fcnt_q;
          fhold_d = fhold_q;
          icnt_d  = icnt_q;
        end
        TRANS_NONSEQ: begin
          case (bus.HBURSTM)
            BURST_INCR16, BURST_WRAP16: begin fcnt_d = 4'd15; fhold_d = 1'b1; end
            BURST_INCR8,  BURST_WRAP8:  begin fcnt_d = 4'd7;  fhold_d = 1'b1; end
            BURST_INCR4,  BURST_WRAP4:  begin fcnt_d = 4'd3;  fhold_d = 1'b1; end
            default:                    begin fcnt_d = 4'd0;  fhold_d = 1'b0; end
          endcase
          icnt_d = (bus.HBURSTM == BURST_INCR) ? 5'd1 : 5'd0;
        end
        default: begin
          // SEQ: 4-bit wrap from 0 is harmless because hold stays 0.
          fcnt_d  = fcnt_q - 4'd1;
          fhold_d = (fcnt_q == 4'd1) ? 1'b0 : fhold_q;
          // Only an INCR burst in progress (nonzero count) accumulates beats,
          // so SEQ beats of fixed bursts never create an INCR hold.
          if (icnt_q != 5'd0)
            icnt_d = (icnt_q >= MAX_BEATS) ? MAX_BEATS : icnt_q + 5'd1;
        end
      endcase
    end

    // A master restarting fixed bursts without finishing them loses its hold
    // on the third such NONSEQ.
    if (is_nonseq && (guard_q == 2'd2)) begin
      fcnt_d  = 4'd0;
      fhold_d = 1'b0;
    end

    guard_d = guard_q;
    if (!fhold_d)
      guard_d = 2'd0;
    else if (is_nonseq && fhold_q)
      guard_d = guard_q + 2'd1;

    incr_hold_d = (icnt_d != 5'd0) && (icnt_d < MAX_BEATS);
  end

  // Round-robin selection starting after the current port, current port last.
  always_comb begin
    hold      = bus.HMASTLOCKM | fhold_d | incr_hold_d;
    cand      = {bus.req_port3, bus.req_port2, bus.req_port1, bus.req_port0};
    if (bus.HSELM && (bus.HTRANSM != TRANS_IDLE))
      cand[addr_q] = 1'b1;
    addr_d    = addr_q;
    no_port_d = 1'b0;
    found     = 1'b0;
    idx       = addr_q;
    if (!hold) begin
      for (int k = 1; k <= 4; k++) begin
        idx = addr_q + 2'(k);
        if (!found && cand[idx]) begin
          found  = 1'b1;
          addr_d = idx;
        end
      end
      if (!found && !bus.HSELM)
        no_port_d = 1'b1;
    end
    arb_event_d = bus.HREADYM &&
                  ((addr_d != addr_q) || (no_port_q && !no_port_d));
  end

  // State update only on completed transfers; arb_event drops on stalls.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fcnt_q      <= 4'd0;
      fhold_q     <= 1'b0;
      guard_q     <= 2'd0;
      icnt_q      <= 5'd0;
      addr_q      <= 2'd0;
      no_port_q   <= 1'b1;
      arb_event_q <= 1'b0;
    end else begin
      arb_event_q <= arb_event_d;
      if (bus.HREADYM) begin
        fcnt_q    <= fcnt_d;
        fhold_q   <= fhold_d;
        guard_q   <= guard_d;
        icnt_q    <= icnt_d;
        addr_q    <= addr_d;
        no_port_q <= no_port_d;
      end
    end
  end

  assign bus.addr_in_port = addr_q;
  assign bus.no_port      = no_port_q;
  assign bus.arb_event    = arb_event_q;

endmodule

// File: tb/tb_nanosoc_rr_arbiter_sram.sv
// Directed bench for nanosoc_rr_arbiter_sram (MAX_INCR_BEATS=4).
module tb_nanosoc_rr_arbiter_sram;

  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, INCR4 = 3'd3, INCR8 = 3'd5;

  logic HCLK;
  logic HRESETn;
  int   n_checks;
  int   n_pass;

  nanosoc_rr_arbiter_sram_if bus ();

  nanosoc_rr_arbiter_sram #(.MAX_INCR_BEATS(4)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus.slave)
  );

  // Clock / reset
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Driver: apply one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic step(input logic [3:0] r, input logic s, input logic [1:0] t,
                      input logic [2:0] b, input logic l, input logic rdy);
    bus.req_port0  = r[0];
    bus.req_port1  = r[1];
    bus.req_port2  = r[2];
    bus.req_port3  = r[3];
    bus.HSELM      = s;
    bus.HTRANSM    = t;
    bus.HBURSTM    = b;
    bus.HMASTLOCKM = l;
    bus.HREADYM    = rdy;
    @(posedge HCLK);
    #1;
  endtask

  // Checker: three immediate assertions per observation point.
  task automatic check(input string tag, input logic [1:0] ea, input logic enp,
                       input logic eev);
    n_checks++;
    assert (bus.addr_in_port === ea) n_pass++;
    else $error("FAIL %s addr_in_port got %0d exp %0d", tag, bus.addr_in_port, ea);
    n_checks++;
    assert (bus.no_port === enp) n_pass++;
    else $error("FAIL %s no_port got %0b exp %0b", tag, bus.no_port, enp);
    n_checks++;
    assert (bus.arb_event === eev) n_pass++;
    else $error("FAIL %s arb_event got %0b exp %0b", tag, bus.arb_event, eev);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    HRESETn  = 1'b0;

    // Reset with all requests high.
    step(4'b1111, 1'b0, IDLE, SINGLE, 1'b0, 1'b1);
    step(4'b1111, 1'b0, IDLE, SINGLE, 1'b0, 1'b1);
    check("in_reset", 2'd0, 1'b1, 1'b0);
    HRESETn = 1'b1;
    step(4'b1111, 1'b0, IDLE, SINGLE, 1'b0, 1'b1);
    check("first_grant", 2'd1, 1'b0, 1'b1);

    // Rotation with all ports requesting, SINGLE transfers.
    step(4'b1111, 1'b1, NONSEQ, SINGLE, 1'b0, 1'b1); check("rot_2", 2'd2, 1'b0, 1'b1);
    step(4'b1111, 1'b1, NONSEQ, SINGLE, 1'b0, 1'b1); check("rot_3", 2'd3, 1'b0, 1'b1);
    step(4'b1111, 1'b1, NONSEQ, SINGLE, 1'b0, 1'b1); check("rot_0", 2'd0, 1'b0, 1'b1);
    step(4'b1111, 1'b1, NONSEQ, SINGLE, 1'b0, 1'b1); check("rot_1", 2'd1, 1'b0, 1'b1);

    // INCR8 from port 2 with req0 waiting: held 8 beats, released on the 8th.
    step(4'b0100, 1'b1, IDLE, SINGLE, 1'b0, 1'b1);   check("to_p2", 2'd2, 1'b0, 1'b1);
    step(4'b0101, 1'b1, NONSEQ, INCR8, 1'b0, 1'b1);  check("incr8_b1", 2'd2, 1'b0, 1'b0);
    for (int i = 2; i <= 7; i++) begin
      step(4'b0101, 1'b1, SEQ, INCR8, 1'b0, 1'b1);
      check($sformatf("incr8_b%0d", i), 2'd2, 1'b0, 1'b0);
    end
    step(4'b0101, 1'b1, SEQ, INCR8, 1'b0, 1'b1);     check("incr8_b8", 2'd0, 1'b0, 1'b1);

    // Undefined-length INCR from port 1, req3 waiting: 4-beat cap.
    step(4'b0010, 1'b1, IDLE, SINGLE, 1'b0, 1'b1);   check("to_p1", 2'd1, 1'b0, 1'b1);
    step(4'b1010, 1'b1, NONSEQ, INCR, 1'b0, 1'b1);   check("incr_b1", 2'd1, 1'b0, 1'b0);
    step(4'b1010, 1'b1, SEQ, INCR, 1'b0, 1'b1);      check("incr_b2", 2'd1, 1'b0, 1'b0);
    step(4'b1010, 1'b1, SEQ, INCR, 1'b0, 1'b1);      check("incr_b3", 2'd1, 1'b0, 1'b0);
    step(4'b1010, 1'b1, SEQ, INCR, 1'b0, 1'b1);      check("incr_b4", 2'd3, 1'b0, 1'b1);

    // Back-to-back INCR4 NONSEQs from port 0, req2 waiting. The guard counts
    // to 2 on the 2nd and 3rd NONSEQ; the next NONSEQ drops the hold.
    step(4'b0001, 1'b1, IDLE, SINGLE, 1'b0, 1'b1);   check("to_p0", 2'd0, 1'b0, 1'b1);
    step(4'b0101, 1'b1, NONSEQ, INCR4, 1'b0, 1'b1);  check("guard_n1", 2'd0, 1'b0, 1'b0);
    step(4'b0101, 1'b1, NONSEQ, INCR4, 1'b0, 1'b1);  check("guard_n2", 2'd0, 1'b0, 1'b0);
    step(4'b0101, 1'b1, NONSEQ, INCR4, 1'b0, 1'b1);  check("guard_n3", 2'd0, 1'b0, 1'b0);
    step(4'b0101, 1'b1, NONSEQ, INCR4, 1'b0, 1'b1);  check("guard_rel", 2'd2, 1'b0, 1'b1);

    // Locked port 3 with req1 waiting, plus a 3-cycle stall with toggling inputs.
    step(4'b1000, 1'b1, IDLE, SINGLE, 1'b0, 1'b1);   check("to_p3", 2'd3, 1'b0, 1'b1);
    step(4'b0010, 1'b1, NONSEQ, SINGLE, 1'b1, 1'b1); check("lock_1", 2'd3, 1'b0, 1'b0);
    step(4'b1111, 1'b1, NONSEQ, SINGLE, 1'b0, 1'b0); check("stall_1", 2'd3, 1'b0, 1'b0);
    step(4'b0001, 1'b0, IDLE, SINGLE, 1'b0, 1'b0);   check("stall_2", 2'd3, 1'b0, 1'b0);
    step(4'b0110, 1'b1, SEQ, SINGLE, 1'b0, 1'b0);    check("stall_3", 2'd3, 1'b0, 1'b0);
    step(4'b0010, 1'b1, NONSEQ, SINGLE, 1'b1, 1'b1); check("lock_2", 2'd3, 1'b0, 1'b0);
    step(4'b0010, 1'b1, IDLE, SINGLE, 1'b0, 1'b1);   check("unlock", 2'd1, 1'b0, 1'b1);

    // Stall right after an event: arb_event forced low, selection frozen.
    step(4'b1111, 1'b1, NONSEQ, SINGLE, 1'b0, 1'b0); check("stall_ev", 2'd1, 1'b0, 1'b0);

    // No requests: no_port asserts when unselected, clears when HSELM returns.
    step(4'b0000, 1'b0, IDLE, SINGLE, 1'b0, 1'b1);   check("no_port_set", 2'd1, 1'b1, 1'b0);
    step(4'b0000, 1'b1, IDLE, SINGLE, 1'b0, 1'b1);   check("no_port_clr", 2'd1, 1'b0, 1'b1);

    // Reset mid-burst, then a stray SEQ with cleared trackers must not hold.
    step(4'b0001, 1'b1, NONSEQ, INCR8, 1'b0, 1'b1);  check("pre_rst", 2'd1, 1'b0, 1'b0);
    HRESETn = 1'b0;
    #1;
    check("mid_rst", 2'd0, 1'b1, 1'b0);
    #2;
    HRESETn = 1'b1;
    step(4'b0100, 1'b1, SEQ, INCR8, 1'b0, 1'b1);     check("post_rst", 2'd2, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
